credential_entry: RTL and testbench
===================================

# credential_entry

Front-end sequencer for the login step of the BitsPlease console. Collects a 16-bit user ID and then a 16-bit password from the toggle switches, one enter-button press each. Writes each word to the access-control block with a one-cycle load strobe, then waits for the grant/deny response. Counts consecutive failures and enforces a lockout; drives the LED/LCD status lines the process control forwards to the board.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 1024: cycles to wait for a response before treating the attempt as denied.
- `MAX_FAILS`, default 3: consecutive denials that trigger lockout (range 1–3).
- `LOCKOUT_CYC`, default 50_000_000: lockout duration in cycles.

Ports (one clock, `clk`; reset `rst` is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: level from process control; login phase active.
- `switches` in 16: toggle switches [15:0].
- `enter_btn` in 1: shaped one-cycle pulse.
- `clear_btn` in 1: shaped one-cycle pulse; aborts the current entry.
- `access_resp_valid` in 1: one-cycle pulse from access control.
- `access_grant` in 1: qualified by `access_resp_valid`.
- `data_out` out 18: `{tag[1:0], value[15:0]}` to access control. Tag 2'b01 = user ID, 2'b10 = password.
- `data_load` out 1: one-cycle strobe; `data_out` is valid only in this cycle.
- `granted` out 1: level.
- `denied` out 1: one-cycle pulse per failed attempt.
- `locked` out 1: level.
- `fail_count` out 2: consecutive failures.
- `lcd_code` out 4: current state code for the LCD select.

## Operation
- FSM states: IDLE, GET_ID, SEND_ID, GET_PW, SEND_PW, WAIT_RESP, GRANTED, DENIED, LOCKED.
- IDLE → GET_ID when `enable`=1.
- GET_ID: on `enter_btn`, register `switches` into `id_reg` and go to SEND_ID.
- SEND_ID (1 cycle): `data_out={2'b01,id_reg}`, `data_load`=1, then go to GET_PW.
- GET_PW: on `enter_btn`, register into `pw_reg` and go to SEND_PW.
- SEND_PW (1 cycle): `data_out={2'b10,pw_reg}`, `data_load`=1, then go to WAIT_RESP. The timeout counter is cleared here.
- WAIT_RESP, with `access_resp_valid`=1:
  - `access_grant`=1 → GRANTED.
  - `access_grant`=0 → DENIED.
- WAIT_RESP timeout: the counter reaching `TIMEOUT_CYC`-1 without a response → DENIED.
- GRANTED: `granted`=1 and `fail_count` cleared. Stays until `enable`=0, then IDLE.
- DENIED (1 cycle): `denied`=1 and `fail_count`+1 (saturating at 3).
  - If the new count is ≥ `MAX_FAILS` → LOCKED.
  - Otherwise → GET_ID, with `id_reg`/`pw_reg` cleared.
- LOCKED: `locked`=1 and all buttons are ignored. After `LOCKOUT_CYC` cycles, `fail_count` is cleared and the FSM goes to IDLE.
- `clear_btn` in GET_ID/GET_PW → GET_ID, with `id_reg` and `pw_reg` cleared.
- `clear_btn` is ignored in SEND_*, WAIT_RESP, DENIED, LOCKED, GRANTED.
- `enable`=0 in any state except LOCKED → IDLE next cycle; registers are cleared and `fail_count` is kept. LOCKED ignores `enable`, so toggling it cannot bypass the lockout.
- `access_resp_valid` outside WAIT_RESP is ignored.
- `enter_btn` outside GET_ID/GET_PW is ignored.
- `data_out` is 18'h0 whenever `data_load`=0.
- `lcd_code` equals the state encoding (IDLE=0 … LOCKED=8).

## Timing
- Reset values:
  - State: IDLE.
  - 0: `data_out`, `data_load`, `granted`, `denied`, `locked`, `fail_count`, `id_reg`, `pw_reg`.
  - `lcd_code`=0.
- All outputs are registered.
- Enter pulse in cycle N → `data_load`=1 in cycle N+1 carrying the switch value sampled in cycle N.
- Response pulse in cycle N → `granted` rises, or `denied` pulses, in cycle N+1.
- Timeout: the last `data_load` (SEND_PW) in cycle N → `denied` in cycle N+1+`TIMEOUT_CYC`.
- Priority within one cycle: `rst` > `enable`=0 > `clear_btn` > `enter_btn`.
- A response arriving in the same cycle the timeout expires: the response wins.
- `rst` mid-operation (e.g. in WAIT_RESP or LOCKED) returns everything to reset values next cycle, including clearing the lockout.

## Structure
- Shared package `access_pkg`:
  - State enum and `lcd_code` encodings.
  - Tag constants `TAG_ID`=2'b01 and `TAG_PW`=2'b10.
  - Data width constant (16) and `data_out` width (18).
- One sub-module, `cycle_timer`: a loadable down-counter with a `done` pulse. It is instantiated twice, once for the response timeout and once for the lockout duration.
- The FSM, capture registers and failure counter live in `credential_entry`.

## Test plan
Bench parameters: `TIMEOUT_CYC`=16, `LOCKOUT_CYC`=32, `MAX_FAILS`=3.

- **Happy path:** `enable`=1; switches=16'h1234 + enter; switches=16'hBEEF + enter.
  - `data_load` pulses with `data_out`=18'h11234, then 18'h2BEEF.
  - Response valid with grant=1 → `granted`=1 and `fail_count`=0.
- **Clear mid-entry:** ID entered; `clear_btn` in GET_PW → back in GET_ID. The next enter with 16'h00AA sends 18'h100AA; no password load occurs in between.
- **Timeout:** full entry, no response → `denied` pulses exactly 17 cycles after the password `data_load`; `fail_count`=1; FSM in GET_ID.
- **Lockout:** three denied attempts → `fail_count`=3 and `locked`=1.
  - During lockout, enter pulses and an `enable` toggle produce no `data_load`.
  - After 32 cycles, `locked`=0, `fail_count`=0, FSM in IDLE.
- **Simultaneous events:**
  - `clear_btn` and `enter_btn` in the same GET_ID cycle → no load.
  - Response and timeout expiry in the same cycle with grant=1 → `granted`=1, no `denied`.
- **Reset mid-WAIT_RESP:** `rst` high for 1 cycle → all outputs 0 next cycle; a later response pulse is ignored.

Source files
------------

// File: rtl/access_pkg.sv
// Shared definitions for the credential entry front end.
//   - FSM state encoding; the same value is shown on the LCD select lines.
//   - Tag values that mark a word sent to access control as user ID or password.
//   - Data widths and a saturating 2-bit increment for the failure counter.
package access_pkg;

    localparam int DATA_W = 16;
    localparam int DOUT_W = 18;

    localparam logic [1:0] TAG_ID = 2'b01;
    localparam logic [1:0] TAG_PW = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_GET_ID    = 4'd1,
        ST_SEND_ID   = 4'd2,
        ST_GET_PW    = 4'd3,
        ST_SEND_PW   = 4'd4,
        ST_WAIT_RESP = 4'd5,
        ST_GRANTED   = 4'd6,
        ST_DENIED    = 4'd7,
        ST_LOCKED    = 4'd8
    } state_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'b01;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter.
//   clk, rst      : clock, synchronous active-high reset
//   load/load_val : load the count (takes priority over counting)
//   run           : decrement while nonzero
//   done          : high while running with the count at zero
// A load value of N-1 makes done assert on the N-th run cycle after the load.
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             run,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (run && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign done = run && (r_count == '0);

endmodule

// File: rtl/credential_entry.sv
// Login sequencer: captures a user ID and a password from the switches,
// sends each to access control with a one-cycle load strobe, waits for the
// grant/deny response, counts consecutive failures and enforces a lockout.
//   clk, rst            : clock, synchronous active-high reset
//   enable              : login phase active (ignored while locked)
//   switches            : value captured on enter_btn
//   enter_btn/clear_btn : one-cycle button pulses
//   access_resp_valid   : response strobe, access_grant qualifies it
//   data_out/data_load  : {tag, value} and its one-cycle strobe
//   granted/denied/locked/fail_count/lcd_code : status, all registered
//
// state      | meaning
// IDLE       | login phase inactive
// GET_ID     | waiting for enter with user ID on switches
// SEND_ID    | data_load of {TAG_ID, id}
// GET_PW     | waiting for enter with password on switches
// SEND_PW    | data_load of {TAG_PW, pw}, response timer loaded
// WAIT_RESP  | waiting for response or timeout
// GRANTED    | access granted until enable drops
// DENIED     | one-cycle denial, decides retry or lockout
// LOCKED     | lockout period, buttons and enable ignored
module credential_entry
    import access_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int MAX_FAILS   = 3,
    parameter int LOCKOUT_CYC = 50_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [DATA_W-1:0]   switches,
    input  logic                enter_btn,
    input  logic                clear_btn,
    input  logic                access_resp_valid,
    input  logic                access_grant,
    output logic [DOUT_W-1:0]   data_out,
    output logic                data_load,
    output logic                granted,
    output logic                denied,
    output logic                locked,
    output logic [1:0]          fail_count,
    output logic [3:0]          lcd_code
);

    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int LOCK_W = $clog2(LOCKOUT_CYC + 1);
    localparam logic [TO_W-1:0]   TO_LOAD    = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD  = LOCK_W'(LOCKOUT_CYC - 1);
    localparam logic [1:0]        FAIL_LIMIT = 2'(MAX_FAILS);

    state_t              r_state;
    logic [DATA_W-1:0]   r_id_reg;
    logic [DATA_W-1:0]   r_pw_reg;
    logic [1:0]          r_fail_cnt;
    logic [DOUT_W-1:0]   r_data_out;
    logic                r_data_load;
    logic                r_granted;
    logic                r_denied;
    logic                r_locked;

    state_t              w_state_nxt;
    logic [DATA_W-1:0]   w_id_nxt;
    logic [DATA_W-1:0]   w_pw_nxt;
    logic [1:0]          w_fail_nxt;
    logic [DOUT_W-1:0]   w_dout_nxt;
    logic                w_to_done;
    logic                w_lock_done;

    cycle_timer #(.WIDTH(TO_W)) u_resp_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (r_state == ST_SEND_PW),
        .load_val (TO_LOAD),
        .run      (r_state == ST_WAIT_RESP),
        .done     (w_to_done)
    );

    // Loaded on every denial; it only counts down once the FSM is locked.
    cycle_timer #(.WIDTH(LOCK_W)) u_lock_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (r_state == ST_DENIED),
        .load_val (LOCK_LOAD),
        .run      (r_state == ST_LOCKED),
        .done     (w_lock_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_id_reg    <= '0;
            r_pw_reg    <= '0;
            r_fail_cnt  <= '0;
            r_data_out  <= '0;
            r_data_load <= 1'b0;
            r_granted   <= 1'b0;
            r_denied    <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_id_reg    <= w_id_nxt;
            r_pw_reg    <= w_pw_nxt;
            r_fail_cnt  <= w_fail_nxt;
            r_data_out  <= w_dout_nxt;
            r_data_load <= (w_state_nxt == ST_SEND_ID) || (w_state_nxt == ST_SEND_PW);
            r_granted   <= (w_state_nxt == ST_GRANTED);
            r_denied    <= (w_state_nxt == ST_DENIED);
            r_locked    <= (w_state_nxt == ST_LOCKED);
        end
    end

    // Outputs are flops loaded from the next-state decode, so each status
    // line lines up with the state it describes without extra latency.
    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id_reg;
        w_pw_nxt    = r_pw_reg;
        w_fail_nxt  = r_fail_cnt;
        w_dout_nxt  = '0;

        if ((r_state != ST_LOCKED) && !enable) begin
            w_state_nxt = ST_IDLE;
            w_id_nxt    = '0;
            w_pw_nxt    = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_GET_ID;
                end
                ST_GET_ID: begin
                    if (clear_btn) begin
                        w_id_nxt = '0;
                        w_pw_nxt = '0;
                    end else if (enter_btn) begin
                        w_id_nxt    = switches;
                        w_state_nxt = ST_SEND_ID;
                    end
                end
                ST_SEND_ID: begin
                    w_state_nxt = ST_GET_PW;
                end
                ST_GET_PW: begin
                    if (clear_btn) begin
                        w_id_nxt    = '0;
                        w_pw_nxt    = '0;
                        w_state_nxt = ST_GET_ID;
                    end else if (enter_btn) begin
                        w_pw_nxt    = switches;
                        w_state_nxt = ST_SEND_PW;
                    end
                end
                ST_SEND_PW: begin
                    w_state_nxt = ST_WAIT_RESP;
                end
                ST_WAIT_RESP: begin
                    // A response in the expiry cycle still counts.
                    if (access_resp_valid) begin
                        if (access_grant) begin
                            w_state_nxt = ST_GRANTED;
                            w_fail_nxt  = '0;
                        end else begin
                            w_state_nxt = ST_DENIED;
                            w_fail_nxt  = sat_inc(r_fail_cnt);
                        end
                    end else if (w_to_done) begin
                        w_state_nxt = ST_DENIED;
                        w_fail_nxt  = sat_inc(r_fail_cnt);
                    end
                end
                ST_GRANTED: begin
                    w_state_nxt = ST_GRANTED;
                end
                ST_DENIED: begin
                    // The count was already bumped on entry to DENIED.
                    w_id_nxt    = '0;
                    w_pw_nxt    = '0;
                    w_state_nxt = (r_fail_cnt >= FAIL_LIMIT) ? ST_LOCKED : ST_GET_ID;
                end
                ST_LOCKED: begin
                    if (w_lock_done) begin
                        w_state_nxt = ST_IDLE;
                        w_fail_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        if (w_state_nxt == ST_SEND_ID) begin
            w_dout_nxt = {TAG_ID, w_id_nxt};
        end else if (w_state_nxt == ST_SEND_PW) begin
            w_dout_nxt = {TAG_PW, w_pw_nxt};
        end
    end

    assign data_out   = r_data_out;
    assign data_load  = r_data_load;
    assign granted    = r_granted;
    assign denied     = r_denied;
    assign locked     = r_locked;
    assign fail_count = r_fail_cnt;
    assign lcd_code   = r_state;

endmodule

// File: tb/tb_credential_entry.sv
module tb_credential_entry;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] switches;
    logic        enter_btn;
    logic        clear_btn;
    logic        access_resp_valid;
    logic        access_grant;
    logic [17:0] data_out;
    logic        data_load;
    logic        granted;
    logic        denied;
    logic        locked;
    logic [1:0]  fail_count;
    logic [3:0]  lcd_code;

    int checks   = 0;
    int failures = 0;

    credential_entry #(
        .TIMEOUT_CYC (16),
        .MAX_FAILS   (3),
        .LOCKOUT_CYC (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .switches          (switches),
        .enter_btn         (enter_btn),
        .clear_btn         (clear_btn),
        .access_resp_valid (access_resp_valid),
        .access_grant      (access_grant),
        .data_out          (data_out),
        .data_load         (data_load),
        .granted           (granted),
        .denied            (denied),
        .locked            (locked),
        .fail_count        (fail_count),
        .lcd_code          (lcd_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are read 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_enter(input logic [15:0] v);
        switches  = v;
        enter_btn = 1'b1;
        step();
        enter_btn = 1'b0;
    endtask

    // Leaves the DUT in WAIT_RESP (one cycle after the password load).
    task automatic run_entry(input logic [15:0] id, input logic [15:0] pw);
        press_enter(id);
        step();
        press_enter(pw);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({data_out, data_load, granted, denied, locked, fail_count, lcd_code} !== 29'h0) begin
            failures++;
            $display("FAIL reset_outputs: got out=%h load=%b g=%b d=%b l=%b fc=%0d lcd=%0d, expected all zero",
                     data_out, data_load, granted, denied, locked, fail_count, lcd_code);
        end
    endtask

    task automatic test_happy_path();
        enable = 1'b1;
        step();
        checks++;
        if (lcd_code !== 4'd1) begin
            failures++; $display("FAIL happy_get_id: lcd=%0d expected 1", lcd_code);
        end
        press_enter(16'h1234);
        checks++;
        if (data_load !== 1'b1 || data_out !== 18'h11234) begin
            failures++; $display("FAIL happy_id_load: load=%b out=%h expected 1 11234", data_load, data_out);
        end
        step();
        checks++;
        if (data_load !== 1'b0 || data_out !== 18'h0 || lcd_code !== 4'd3) begin
            failures++; $display("FAIL happy_get_pw: load=%b out=%h lcd=%0d expected 0 0 3", data_load, data_out, lcd_code);
        end
        press_enter(16'hBEEF);
        checks++;
        if (data_load !== 1'b1 || data_out !== 18'h2BEEF) begin
            failures++; $display("FAIL happy_pw_load: load=%b out=%h expected 1 2beef", data_load, data_out);
        end
        step();
        access_resp_valid = 1'b1;
        access_grant      = 1'b1;
        step();
        access_resp_valid = 1'b0;
        access_grant      = 1'b0;
        checks++;
        if (granted !== 1'b1 || fail_count !== 2'd0 || lcd_code !== 4'd6 || denied !== 1'b0) begin
            failures++; $display("FAIL happy_granted: g=%b fc=%0d lcd=%0d d=%b expected 1 0 6 0", granted, fail_count, lcd_code, denied);
        end
        step();
        checks++;
        if (granted !== 1'b1) begin
            failures++; $display("FAIL happy_granted_hold: g=%b expected 1", granted);
        end
        enable = 1'b0;
        step();
        checks++;
        if (granted !== 1'b0 || lcd_code !== 4'd0) begin
            failures++; $display("FAIL happy_disable: g=%b lcd=%0d expected 0 0", granted, lcd_code);
        end
    endtask

    task automatic test_clear();
        enable = 1'b1;
        step();
        press_enter(16'h1111);
        step();
        clear_btn = 1'b1;
        step();
        clear_btn = 1'b0;
        checks++;
        if (lcd_code !== 4'd1 || data_load !== 1'b0) begin
            failures++; $display("FAIL clear_to_get_id: lcd=%0d load=%b expected 1 0", lcd_code, data_load);
        end
        press_enter(16'h00AA);
        checks++;
        if (data_load !== 1'b1 || data_out !== 18'h100AA) begin
            failures++; $display("FAIL clear_reentry: load=%b out=%h expected 1 100aa", data_load, data_out);
        end
    endtask

    // Continues from the SEND_ID cycle left by test_clear.
    task automatic test_timeout();
        int  k;
        bit  found;
        bit  extra_load;
        k = 0;
        found = 1'b0;
        extra_load = 1'b0;
        step();
        press_enter(16'h5555);
        checks++;
        if (data_load !== 1'b1 || data_out !== 18'h25555) begin
            failures++; $display("FAIL timeout_pw_load: load=%b out=%h expected 1 25555", data_load, data_out);
        end
        for (int i = 1; i <= 40 && !found; i++) begin
            step();
            if (data_load) extra_load = 1'b1;
            if (denied === 1'b1) begin
                found = 1'b1;
                k = i;
            end
        end
        checks++;
        if (!found || k != 17) begin
            failures++; $display("FAIL timeout_latency: denied after %0d cycles (found=%0d) expected 17", k, found);
        end
        checks++;
        if (fail_count !== 2'd1 || extra_load) begin
            failures++; $display("FAIL timeout_fail_count: fc=%0d extra_load=%0d expected 1 0", fail_count, extra_load);
        end
        step();
        checks++;
        if (denied !== 1'b0 || lcd_code !== 4'd1) begin
            failures++; $display("FAIL timeout_retry: d=%b lcd=%0d expected 0 1", denied, lcd_code);
        end
    endtask

    task automatic test_lockout();
        int  lock_len;
        bit  found;
        bit  seen_load;
        lock_len = 0;
        found = 1'b0;
        seen_load = 1'b0;
        run_entry(16'h0001, 16'h0002);
        access_resp_valid = 1'b1;
        step();
        access_resp_valid = 1'b0;
        checks++;
        if (denied !== 1'b1 || fail_count !== 2'd2 || lcd_code !== 4'd7) begin
            failures++; $display("FAIL lock_second_deny: d=%b fc=%0d lcd=%0d expected 1 2 7", denied, fail_count, lcd_code);
        end
        step();
        run_entry(16'h0003, 16'h0004);
        access_resp_valid = 1'b1;
        step();
        access_resp_valid = 1'b0;
        checks++;
        if (denied !== 1'b1 || fail_count !== 2'd3) begin
            failures++; $display("FAIL lock_third_deny: d=%b fc=%0d expected 1 3", denied, fail_count);
        end
        step();
        checks++;
        if (locked !== 1'b1 || lcd_code !== 4'd8 || fail_count !== 2'd3 || denied !== 1'b0) begin
            failures++; $display("FAIL lock_entered: l=%b lcd=%0d fc=%0d d=%b expected 1 8 3 0", locked, lcd_code, fail_count, denied);
        end
        for (int j = 1; j <= 100 && !found; j++) begin
            switches  = 16'hFFFF;
            enter_btn = j[0];
            clear_btn = (j == 3);
            if (j == 5) enable = 1'b0;
            if (j == 9) enable = 1'b1;
            step();
            if (data_load) seen_load = 1'b1;
            if (locked !== 1'b1) begin
                found = 1'b1;
                lock_len = j;
            end
        end
        enter_btn = 1'b0;
        clear_btn = 1'b0;
        checks++;
        if (!found || lock_len != 32) begin
            failures++; $display("FAIL lock_duration: locked ended after %0d more cycles (found=%0d) expected 32", lock_len, found);
        end
        checks++;
        if (seen_load) begin
            failures++; $display("FAIL lock_no_load: data_load seen=%0d expected 0", seen_load);
        end
        checks++;
        if (locked !== 1'b0 || fail_count !== 2'd0 || lcd_code !== 4'd0) begin
            failures++; $display("FAIL lock_release: l=%b fc=%0d lcd=%0d expected 0 0 0", locked, fail_count, lcd_code);
        end
        step();
        checks++;
        if (lcd_code !== 4'd1) begin
            failures++; $display("FAIL lock_rearm: lcd=%0d expected 1", lcd_code);
        end
    endtask

    task automatic test_simultaneous();
        switches  = 16'hABCD;
        clear_btn = 1'b1;
        enter_btn = 1'b1;
        step();
        clear_btn = 1'b0;
        enter_btn = 1'b0;
        checks++;
        if (data_load !== 1'b0 || data_out !== 18'h0 || lcd_code !== 4'd1) begin
            failures++; $display("FAIL clear_beats_enter: load=%b out=%h lcd=%0d expected 0 0 1", data_load, data_out, lcd_code);
        end
        run_entry(16'h0A0A, 16'h0B0B);
        repeat (15) step();
        checks++;
        if (lcd_code !== 4'd5 || denied !== 1'b0) begin
            failures++; $display("FAIL race_still_waiting: lcd=%0d d=%b expected 5 0", lcd_code, denied);
        end
        access_resp_valid = 1'b1;
        access_grant      = 1'b1;
        step();
        access_resp_valid = 1'b0;
        access_grant      = 1'b0;
        checks++;
        if (granted !== 1'b1 || denied !== 1'b0 || fail_count !== 2'd0) begin
            failures++; $display("FAIL race_response_wins: g=%b d=%b fc=%0d expected 1 0 0", granted, denied, fail_count);
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_wait();
        enable = 1'b1;
        step();
        run_entry(16'hCAFE, 16'hF00D);
        checks++;
        if (lcd_code !== 4'd5) begin
            failures++; $display("FAIL rst_setup_wait: lcd=%0d expected 5", lcd_code);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({data_out, data_load, granted, denied, locked, fail_count, lcd_code} !== 29'h0) begin
            failures++;
            $display("FAIL rst_mid_wait: got out=%h load=%b g=%b d=%b l=%b fc=%0d lcd=%0d, expected all zero",
                     data_out, data_load, granted, denied, locked, fail_count, lcd_code);
        end
        access_resp_valid = 1'b1;
        access_grant      = 1'b1;
        step();
        access_resp_valid = 1'b0;
        access_grant      = 1'b0;
        checks++;
        if (granted !== 1'b0 || denied !== 1'b0 || lcd_code !== 4'd1) begin
            failures++; $display("FAIL rst_stale_resp: g=%b d=%b lcd=%0d expected 0 0 1", granted, denied, lcd_code);
        end
    endtask

    initial begin
        rst               = 1'b1;
        enable            = 1'b0;
        switches          = 16'h0;
        enter_btn         = 1'b0;
        clear_btn         = 1'b0;
        access_resp_valid = 1'b0;
        access_grant      = 1'b0;
        #2;
        test_reset();
        test_happy_path();
        test_clear();
        test_timeout();
        test_lockout();
        test_simultaneous();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
